// File: rtl/pc_branch_ctrl.sv
// Program counter, Z/N flag memory and write-back branch resolution.
// A taken branch redirects the PC, pulses flush/taken and discards the younger in-flight slots.
//
// Handshake: this block has no valid/ready pair. wb_valid qualifies the WB inputs on each
// rising clock edge and cannot be back-pressured. stall only freezes PC advance; it never
// blocks a redirect.
module pc_branch_ctrl #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  BRANCH_DELAY = 2,
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 wb_valid,
    input  logic                 wb_branch_zero,
    input  logic                 wb_branch_neg,
    input  logic                 wb_jump,
    input  logic [PC_WIDTH-1:0]  wb_target,
    input  logic                 wb_flag_wr,
    input  logic                 wb_z,
    input  logic                 wb_n,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 fetch_valid,
    output logic                 flush,
    output logic                 taken,
    output logic                 z_flag,
    output logic                 n_flag,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic                 dbgState
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [2:0] SQUASH_INIT = 3'(BRANCH_DELAY);

    state_t               state;
    state_t               nextState;
    logic [2:0]           squashCnt;
    logic [2:0]           nextSquashCnt;
    logic                 effValid;
    logic                 cond;
    logic [PC_WIDTH-1:0]  nextPc;
    logic [CNT_WIDTH-1:0] nextCount;

    // Branch conditions use the flags stored by an earlier instruction.
    // The current instruction's wb_z/wb_n are not used here.
    always_comb begin
        effValid = wb_valid && (state == RUN);
        cond     = effValid && (wb_jump
                                || (wb_branch_zero && z_flag)
                                || (wb_branch_neg  && n_flag));
    end

    always_comb begin
        nextState     = state;
        nextSquashCnt = squashCnt;
        case (state)
            RUN: begin
                if (cond) begin
                    nextState     = SQUASH;
                    nextSquashCnt = SQUASH_INIT;
                end
            end
            SQUASH: begin
                // Count only unstalled cycles.
                // Each unstalled cycle retires one younger slot.
                if (!stall) begin
                    if (squashCnt <= 3'd1) begin
                        nextState     = RUN;
                        nextSquashCnt = 3'd0;
                    end else begin
                        nextSquashCnt = squashCnt - 3'd1;
                    end
                end
            end
            default: begin
                nextState     = RUN;
                nextSquashCnt = 3'd0;
            end
        endcase
    end

    always_comb begin
        nextPc = pc + PC_WIDTH'(1);
        if (cond) begin
            nextPc = wb_target;
        end else if (stall) begin
            nextPc = pc;
        end
    end

    always_comb begin
        nextCount = taken_count;
        if (cond && (taken_count != '1)) begin
            nextCount = taken_count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= RUN;
            squashCnt <= 3'd0;
        end else begin
            state     <= nextState;
            squashCnt <= nextSquashCnt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            flush       <= 1'b0;
            taken       <= 1'b0;
            taken_count <= '0;
        end else begin
            pc          <= nextPc;
            flush       <= cond;
            taken       <= cond;
            taken_count <= nextCount;
        end
    end

    // Flags update after cond has already sampled the old values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            z_flag <= 1'b0;
            n_flag <= 1'b0;
        end else if (effValid && wb_flag_wr) begin
            z_flag <= wb_z;
            n_flag <= wb_n;
        end
    end

    assign fetch_valid = reset_n && !stall;
    assign dbgState    = state;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl.
// Directed steps are followed by a randomized run, and every step is checked against a slot-level reference model.
module tb_pc_branch_ctrl;

    localparam int         PCW  = 8;
    localparam logic [7:0] RPC  = 8'hFD;
    localparam int         BD   = 2;
    localparam int         CW   = 2;
    localparam int         CMAX = 3;

    logic           clock;
    logic           reset_n;
    logic           stall;
    logic           wb_valid;
    logic           wb_branch_zero;
    logic           wb_branch_neg;
    logic           wb_jump;
    logic [PCW-1:0] wb_target;
    logic           wb_flag_wr;
    logic           wb_z;
    logic           wb_n;
    logic [PCW-1:0] pc;
    logic           fetch_valid;
    logic           flush;
    logic           taken;
    logic           z_flag;
    logic           n_flag;
    logic [CW-1:0]  taken_count;
    logic           dbgState;

    int checkCnt = 0;
    int failCnt  = 0;

    // Reference model: the architectural PC, the flags and the count, plus the number of younger slots still to discard.
    logic [PCW-1:0] mPc;
    logic           mZ;
    logic           mN;
    int             mCount;
    int             ignoreLeft;
    logic           mRedirect;

    pc_branch_ctrl #(
        .PC_WIDTH    (PCW),
        .RESET_PC    (RPC),
        .BRANCH_DELAY(BD),
        .CNT_WIDTH   (CW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_branch_zero(wb_branch_zero),
        .wb_branch_neg (wb_branch_neg),
        .wb_jump       (wb_jump),
        .wb_target     (wb_target),
        .wb_flag_wr    (wb_flag_wr),
        .wb_z          (wb_z),
        .wb_n          (wb_n),
        .pc            (pc),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .taken         (taken),
        .z_flag        (z_flag),
        .n_flag        (n_flag),
        .taken_count   (taken_count),
        .dbgState      (dbgState)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp)
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("pc",          32'(pc),          32'(mPc));
        check("flush",       32'(flush),       32'(mRedirect));
        check("taken",       32'(taken),       32'(mRedirect));
        check("z_flag",      32'(z_flag),      32'(mZ));
        check("n_flag",      32'(n_flag),      32'(mN));
        check("taken_count", 32'(taken_count), 32'(mCount));
        check("fetch_valid", 32'(fetch_valid), 32'(reset_n && !stall));
    endtask

    task automatic modelReset();
        mPc        = RPC;
        mZ         = 1'b0;
        mN         = 1'b0;
        mCount     = 0;
        ignoreLeft = 0;
        mRedirect  = 1'b0;
    endtask

    // Driver tasks
    task automatic clearWb();
        wb_valid       = 1'b0;
        wb_branch_zero = 1'b0;
        wb_branch_neg  = 1'b0;
        wb_jump        = 1'b0;
        wb_target      = '0;
        wb_flag_wr     = 1'b0;
        wb_z           = 1'b0;
        wb_n           = 1'b0;
    endtask

    task automatic driveJump(input logic [PCW-1:0] t);
        clearWb();
        wb_valid  = 1'b1;
        wb_jump   = 1'b1;
        wb_target = t;
    endtask

    task automatic driveFlagWr(input logic z, input logic n);
        clearWb();
        wb_valid   = 1'b1;
        wb_flag_wr = 1'b1;
        wb_z       = z;
        wb_n       = n;
    endtask

    // Reset asserted between edges.
    // The outputs are checked while reset is held, and reset is released at the next falling edge.
    task automatic doReset();
        reset_n = 1'b0;
        #1;
        modelReset();
        check("rst_pc",          32'(pc),          32'(RPC));
        check("rst_flush",       32'(flush),       32'd0);
        check("rst_taken",       32'(taken),       32'd0);
        check("rst_z",           32'(z_flag),      32'd0);
        check("rst_n",           32'(n_flag),      32'd0);
        check("rst_count",       32'(taken_count), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock: evaluate the model on the inputs now applied, pass the edge, then compare.
    task automatic step();
        logic accepted;
        logic redirect;
        accepted = wb_valid && (ignoreLeft == 0);
        redirect = accepted && (wb_jump || (wb_branch_zero && mZ) || (wb_branch_neg && mN));
        @(posedge clock);
        #1;
        if (redirect) begin
            mPc = wb_target;
        end else if (!stall) begin
            mPc = mPc + 8'd1;
        end
        if (accepted && wb_flag_wr) begin
            mZ = wb_z;
            mN = wb_n;
        end
        if (redirect && mCount < CMAX) begin
            mCount++;
        end
        if (redirect) begin
            ignoreLeft = BD;
        end else if (ignoreLeft > 0 && !stall) begin
            ignoreLeft--;
        end
        mRedirect = redirect;
        checkAll();
    endtask

    int expCnt[5] = '{1, 2, 3, 3, 3};
    logic [PCW-1:0] pcBefore;

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        clearWb();
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        doReset();

        // Idle fetch: FD, FE, FF, 00, 01, 02 (wraps)
        for (int i = 0; i < 5; i++) begin
            step();
        end
        check("idle_pc", 32'(pc), 32'h02);

        // Flag writer sets Z, then branch-if-zero is taken
        driveFlagWr(1'b1, 1'b0);
        step();
        clearWb();
        wb_valid       = 1'b1;
        wb_branch_zero = 1'b1;
        wb_target      = 8'h40;
        step();
        check("bz_pc",    32'(pc),          32'h40);
        check("bz_flush", 32'(flush),       32'd1);
        check("bz_count", 32'(taken_count), 32'd1);

        // Younger slots are discarded, even when they carry a jump
        driveJump(8'h99);
        step();
        check("sq_pc0",    32'(pc),    32'h41);
        check("sq_flush0", 32'(flush), 32'd0);
        step();
        check("sq_pc1", 32'(pc), 32'h42);
        clearWb();
        step();

        // Same instruction writes Z and branches on Z: the old Z=0 is used
        driveFlagWr(1'b0, 1'b0);
        step();
        pcBefore = pc;
        clearWb();
        wb_valid       = 1'b1;
        wb_branch_zero = 1'b1;
        wb_flag_wr     = 1'b1;
        wb_z           = 1'b1;
        wb_target      = 8'h77;
        step();
        check("same_taken", 32'(taken), 32'd0);
        check("same_pc",    32'(pc),    32'(pcBefore + 8'd1));
        clearWb();
        step();
        check("same_zflag", 32'(z_flag), 32'd1);

        // Jump while stalled: redirect wins, and the squash waits for stall to drop
        stall = 1'b1;
        driveJump(8'h10);
        step();
        check("stall_pc",    32'(pc),    32'h10);
        check("stall_taken", 32'(taken), 32'd1);
        driveJump(8'h20);
        repeat (3) step();
        check("stall_hold", 32'(pc), 32'h10);
        stall = 1'b0;
        step();
        step();
        check("stall_sq_pc", 32'(pc), 32'h12);
        step();
        check("stall_resume", 32'(pc), 32'h20);
        clearWb();
        repeat (2) step();

        // Saturating count with a 2-bit counter
        @(posedge clock);
        #1;
        doReset();
        for (int k = 0; k < 5; k++) begin
            driveJump(8'h30 + 8'(k));
            step();
            check("sat_count", 32'(taken_count), 32'(expCnt[k]));
            clearWb();
            repeat (2) step();
        end

        // Reset in the middle of the squash window; the next jump is accepted at once
        driveJump(8'h60);
        step();
        doReset();
        driveJump(8'h55);
        step();
        check("postrst_pc",    32'(pc),          32'h55);
        check("postrst_taken", 32'(taken),       32'd1);
        check("postrst_count", 32'(taken_count), 32'd1);
        clearWb();
        repeat (2) step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end
            stall          = ($urandom_range(0, 3) == 0);
            wb_valid       = ($urandom_range(0, 9) < 7);
            wb_jump        = ($urandom_range(0, 9) == 0);
            wb_branch_zero = ($urandom_range(0, 3) == 0);
            wb_branch_neg  = ($urandom_range(0, 3) == 0);
            wb_flag_wr     = ($urandom_range(0, 1) == 1);
            wb_z           = ($urandom_range(0, 1) == 1);
            wb_n           = ($urandom_range(0, 1) == 1);
            wb_target      = 8'($urandom_range(0, 255));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
Parametrised program-counter and branch-resolution unit for the pipelined datapath. Owns the PC register, the persistent Z/N flag memory (flags of the last flag-writing instruction), and taken-branch redirection with a flush pulse and a squash window for younger in-flight instructions. Sits between instruction memory (IF) and the write-back stage, where branches resolve.

Parameters:
PC_WIDTH, 32, width of PC and jump target; PC wraps modulo 2^PC_WIDTH
RESET_PC, 0, PC value loaded on reset
BRANCH_DELAY, 2, number of younger instructions in flight when a branch resolves in WB (legal range 1..7)
CNT_WIDTH, 16, width of the saturating taken-branch counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
stall  input  1  hold PC; no fetch advance
wb_valid  input  1  WB stage holds a real instruction this cycle
wb_branch_zero  input  1  instruction is branch-if-zero
wb_branch_neg  input  1  instruction is branch-if-negative
wb_jump  input  1  unconditional jump
wb_target  input  PC_WIDTH  resolved target (xrt or memory word, already muxed)
wb_flag_wr  input  1  instruction updates Z/N flags
wb_z  input  1  ALU zero result of WB instruction
wb_n  input  1  ALU negative result of WB instruction
pc  output  PC_WIDTH  current fetch address (registered)
fetch_valid  output  1  fetch at pc is architecturally valid
flush  output  1  one-cycle pulse: clear IF/ID and ID/EX buffers
taken  output  1  one-cycle pulse: branch/jump redirected PC
z_flag  output  1  stored zero flag
n_flag  output  1  stored negative flag
taken_count  output  CNT_WIDTH  taken branches since reset, saturating

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, z_flag=0, n_flag=0, flush=0, taken=0, taken_count=0, state=RUN, squash_cnt=0; fetch_valid=0 while reset_n=0.
- eff_valid = wb_valid && (state==RUN).
- cond = eff_valid && (wb_jump || (wb_branch_zero && z_flag) || (wb_branch_neg && n_flag)). Condition uses STORED flags (previous flag-writing instruction), never the same instruction's wb_z/wb_n.
- Flags: on clock edge with eff_valid && wb_flag_wr: z_flag<=wb_z, n_flag<=wb_n. Update happens after cond is evaluated in the same cycle. Squashed instructions never update flags.
- PC next-state priority: cond -> pc<=wb_target (overrides stall); else stall -> hold; else pc<=pc+1 (wraps, all-ones -> 0).
- FSM, 2 states:
  RUN: on cond -> flush<=1, taken<=1, taken_count<=taken_count+1 unless all-ones, squash_cnt<=BRANCH_DELAY, go SQUASH. Otherwise flush=taken=0.
  SQUASH: flush=taken=0; wb_valid ignored (bubbles or flushed slots); squash_cnt decrements each cycle stall=0, holds when stall=1; when squash_cnt reaches 1 and stall=0 -> RUN next cycle. No new redirect accepted in SQUASH.
- Registered outputs: pc, flush, taken, z_flag, n_flag, taken_count. fetch_valid is combinational: reset_n && !stall.
- Latency: redirect visible on pc one cycle after cond cycle; flush and taken asserted in that same cycle.
- Boundaries: taken_count saturates at 2^CNT_WIDTH-1 (no wrap). Branch with wb_target==pc still counts as taken and flushes. Reset mid-SQUASH returns immediately to RUN with squash_cnt=0. Simultaneous cond and stall: redirect wins, then squash counting waits for stall release.

Test Plan:
- Reset release, stall=0, no WB traffic, 5 cycles -> pc 0,1,2,3,4,5; flush=taken=0; fetch_valid=1.
- PC_WIDTH=4, RESET_PC=14, 3 cycles -> pc 14,15,0,1 (wrap).
- Flag-writer with wb_z=1, then branch_zero target 0x40 next cycle -> pc=0x40 next edge, flush=taken=1 for exactly one cycle, taken_count=1; next BRANCH_DELAY=2 cycles wb_valid=1 jump target 0x99 ignored; pc 0x41,0x42.
- Branch_zero with wb_z=1 and wb_flag_wr=1 on the same instruction, z_flag=0 -> not taken; z_flag=1 afterwards.
- stall=1 with wb_jump target 0x10 -> pc=0x10 despite stall; squash_cnt holds during stall; RUN resumes 2 unstalled cycles after stall drops.
- CNT_WIDTH=2, 5 jumps spaced past the squash window -> taken_count 1,2,3,3,3; reset_n pulse mid-SQUASH -> pc=RESET_PC, flags and count 0, next jump accepted immediately.
